// File: rtl/rst_sync_seq_if.sv
// Reset sequencer bus: soft-reset request in, sequenced resets and ready out.
// Latency: n/a (signal bundle only).
// Backpressure: none; all signals are plain levels.
interface rst_sync_seq_if #(
    parameter int NUM_CH = 3
);
    logic              SW_RST;    // soft-reset request, active high, clk domain
    logic [NUM_CH-1:0] SYNC_RST;  // sequenced resets, active low, bit k -> sub-block k
    logic              READY;     // every SYNC_RST bit released

    // master: the controller that requests soft resets and watches progress
    modport master (output SW_RST, input SYNC_RST, input READY);
    // slave: the reset sequencer itself
    modport slave  (input SW_RST, output SYNC_RST, output READY);
endinterface

// File: rtl/rst_sync_seq.sv
// Reset synchroniser/sequencer: async assert, sync staggered release of NUM_CH resets.
// Latency: first release NUM_STAGES+MIN_ASSERT edges after RST rises, then one per STAGGER.
// Backpressure: none; SW_RST is a level that holds every output asserted while high.
//
// Ports: clk (domain clock), RST (async active-low chip reset),
//        bus.SW_RST (in), bus.SYNC_RST[NUM_CH] (out), bus.READY (out).
module rst_sync_seq #(
    parameter int NUM_STAGES = 2,
    parameter int NUM_CH     = 3,
    parameter int MIN_ASSERT = 4,
    parameter int STAGGER    = 2,
    parameter int ORDER      = 0
) (
    input  logic          clk,
    input  logic          RST,
    rst_sync_seq_if.slave bus
);
    localparam int CNT_MAX = (MIN_ASSERT > STAGGER) ? MIN_ASSERT : STAGGER;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_ASSERT - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t                state;
    logic [NUM_STAGES-1:0] sync_q;
    logic [CW-1:0]         cnt;
    logic [NUM_CH-1:0]     sync_rst_q;
    logic                  ready_q;
    logic [NUM_CH-1:0]     next_mask;
    logic                  rst_ok;

    assign rst_ok       = sync_q[NUM_STAGES-1];
    assign bus.SYNC_RST = sync_rst_q;
    assign bus.READY    = ready_q;

    // Released channels form a contiguous run growing from the first channel in
    // release order, so the next release pattern is a one-step shift-in of a 1.
    // From all zeros this yields just the first channel.
    always_comb begin
        next_mask = sync_rst_q;
        if (ORDER == 0) begin
            next_mask[0] = 1'b1;
            for (int k = 1; k < NUM_CH; k++) next_mask[k] = sync_rst_q[k-1];
        end else begin
            next_mask[NUM_CH-1] = 1'b1;
            for (int k = 0; k < NUM_CH - 1; k++) next_mask[k] = sync_rst_q[k+1];
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            sync_q     <= '0;
            state      <= HOLD;
            cnt        <= '0;
            sync_rst_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], 1'b1};
            case (state)
                HOLD: begin
                    // Any edge without a clean reset release restarts the hold time.
                    if (!rst_ok || bus.SW_RST) begin
                        cnt <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        cnt        <= '0;
                        sync_rst_q <= next_mask;
                        if (&next_mask) begin
                            ready_q <= 1'b1;
                            state   <= RUN;
                        end else begin
                            state   <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    // Soft reset wins over a release due on the same edge.
                    if (bus.SW_RST) begin
                        cnt        <= '0;
                        sync_rst_q <= '0;
                        ready_q    <= 1'b0;
                        state      <= HOLD;
                    end else if (cnt == STAG_LAST) begin
                        cnt        <= '0;
                        sync_rst_q <= next_mask;
                        if (&next_mask) begin
                            ready_q <= 1'b1;
                            state   <= RUN;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (bus.SW_RST) begin
                        cnt        <= '0;
                        sync_rst_q <= '0;
                        ready_q    <= 1'b0;
                        state      <= HOLD;
                    end
                end
                default: begin
                    cnt        <= '0;
                    sync_rst_q <= '0;
                    ready_q    <= 1'b0;
                    state      <= HOLD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rst_sync_seq.sv
// Bench for rst_sync_seq: three instances (defaults, descending order, single channel).
// Latency: checks each output one step after the clock edge it belongs to.
// Backpressure: n/a; stimulus is fixed per cycle.
module tb_rst_sync_seq;
    logic clk;
    logic RST;

    rst_sync_seq_if #(.NUM_CH(3)) if0 ();
    rst_sync_seq_if #(.NUM_CH(3)) if1 ();
    rst_sync_seq_if #(.NUM_CH(1)) if2 ();

    rst_sync_seq #(.NUM_STAGES(2), .NUM_CH(3), .MIN_ASSERT(4), .STAGGER(2), .ORDER(0))
        dut0 (.clk(clk), .RST(RST), .bus(if0));
    rst_sync_seq #(.NUM_STAGES(2), .NUM_CH(3), .MIN_ASSERT(4), .STAGGER(2), .ORDER(1))
        dut1 (.clk(clk), .RST(RST), .bus(if1));
    rst_sync_seq #(.NUM_STAGES(3), .NUM_CH(1), .MIN_ASSERT(1), .STAGGER(1), .ORDER(0))
        dut2 (.clk(clk), .RST(RST), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         edge_n;
        logic [2:0] e0;
        logic [2:0] e1;
        logic       e2;
    } po_t;

    typedef struct {
        logic [2:0] e0;
        logic [2:0] e1;
        logic       e2;
        bit         all;
        string      nm;
    } exp_t;

    po_t  po[11];
    exp_t sb[$];
    int   ntests = 0;
    int   nfail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive SW_RST of instance 0 for one edge, queue the expectation, and
    // compare once the edge has produced its outputs.
    task automatic step(input logic sw, input logic [2:0] e0, input logic [2:0] e1,
                        input logic e2, input bit all, input string nm);
        exp_t v;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.all = all; v.nm = nm;
        if0.SW_RST = sw;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            v = sb.pop_front();
            chk({v.nm, "_sync0"}, 32'(if0.SYNC_RST), 32'(v.e0));
            chk({v.nm, "_rdy0"},  32'(if0.READY),    32'(&v.e0));
            if (v.all) begin
                chk({v.nm, "_sync1"}, 32'(if1.SYNC_RST), 32'(v.e1));
                chk({v.nm, "_rdy1"},  32'(if1.READY),    32'(&v.e1));
                chk({v.nm, "_sync2"}, 32'(if2.SYNC_RST), 32'(v.e2));
                chk({v.nm, "_rdy2"},  32'(if2.READY),    32'(v.e2));
            end
        end
    endtask

    task automatic hstep(input logic sw, input logic [2:0] e0, input string nm);
        step(sw, e0, 3'b000, 1'b0, 1'b0, nm);
    endtask

    // Standard release after SW_RST is first sampled low on the first edge here:
    // first channel at S+3, then every 2 edges.
    task automatic release_seq(input string nm);
        hstep(1'b0, 3'b000, {nm, "_s0"});
        hstep(1'b0, 3'b000, {nm, "_s1"});
        hstep(1'b0, 3'b000, {nm, "_s2"});
        hstep(1'b0, 3'b001, {nm, "_s3"});
        hstep(1'b0, 3'b001, {nm, "_s4"});
        hstep(1'b0, 3'b011, {nm, "_s5"});
        hstep(1'b0, 3'b011, {nm, "_s6"});
        hstep(1'b0, 3'b111, {nm, "_s7"});
    endtask

    task automatic power_on(input string nm);
        for (int i = 0; i < 11; i++)
            step(1'b0, po[i].e0, po[i].e1, po[i].e2, 1'b1, $sformatf("%s_e%0d", nm, po[i].edge_n));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_sync0"}, 32'(if0.SYNC_RST), 32'd0);
        chk({nm, "_rdy0"},  32'(if0.READY),    32'd0);
        chk({nm, "_sync1"}, 32'(if1.SYNC_RST), 32'd0);
        chk({nm, "_rdy1"},  32'(if1.READY),    32'd0);
        chk({nm, "_sync2"}, 32'(if2.SYNC_RST), 32'd0);
        chk({nm, "_rdy2"},  32'(if2.READY),    32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // edge, ORDER=0, ORDER=1, single-channel (NUM_STAGES=3, MIN_ASSERT=1)
        po[0]  = '{1,  3'b000, 3'b000, 1'b0};
        po[1]  = '{2,  3'b000, 3'b000, 1'b0};
        po[2]  = '{3,  3'b000, 3'b000, 1'b0};
        po[3]  = '{4,  3'b000, 3'b000, 1'b1};
        po[4]  = '{5,  3'b000, 3'b000, 1'b1};
        po[5]  = '{6,  3'b001, 3'b100, 1'b1};
        po[6]  = '{7,  3'b001, 3'b100, 1'b1};
        po[7]  = '{8,  3'b011, 3'b110, 1'b1};
        po[8]  = '{9,  3'b011, 3'b110, 1'b1};
        po[9]  = '{10, 3'b111, 3'b111, 1'b1};
        po[10] = '{11, 3'b111, 3'b111, 1'b1};

        if0.SW_RST = 1'b0;
        if1.SW_RST = 1'b0;
        if2.SW_RST = 1'b0;
        RST = 1'b1;
        #1 RST = 1'b0;
        #1 chk_all_zero("reset_async");
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset_held");
        @(negedge clk);
        RST = 1'b1;

        // Power-on sequence on all three instances.
        power_on("pwr");

        // One-cycle soft reset in RUN.
        hstep(1'b1, 3'b000, "sw1_T");
        release_seq("sw1");

        // Soft reset held for 10 edges.
        for (int i = 0; i < 10; i++) hstep(1'b1, 3'b000, $sformatf("swhold_%0d", i));
        release_seq("swhold");

        // Soft reset collides with the ch1 release edge.
        hstep(1'b1, 3'b000, "coll_T");
        hstep(1'b0, 3'b000, "coll_a");
        hstep(1'b0, 3'b000, "coll_b");
        hstep(1'b0, 3'b000, "coll_c");
        hstep(1'b0, 3'b001, "coll_first");
        hstep(1'b0, 3'b001, "coll_wait");
        hstep(1'b1, 3'b000, "coll_hit");
        release_seq("coll_after");

        // RST pulse mid-cycle while at 011, then full power-on again.
        hstep(1'b1, 3'b000, "rp_T");
        hstep(1'b0, 3'b000, "rp_a");
        hstep(1'b0, 3'b000, "rp_b");
        hstep(1'b0, 3'b000, "rp_c");
        hstep(1'b0, 3'b001, "rp_d");
        hstep(1'b0, 3'b001, "rp_e");
        hstep(1'b0, 3'b011, "rp_f");
        #2 RST = 1'b0;
        #1 chk_all_zero("rst_pulse");
        RST = 1'b1;
        power_on("repwr");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/rst_sync_seq.md
Name: rst_sync_seq

Overview:
- Parametrised next-generation reset synchroniser for the multi-clock system. One instance serves one clock domain.
- Asserts NUM_CH active-low reset outputs asynchronously, then releases them synchronously.
- Release happens after a programmable minimum hold, one channel at a time, STAGGER cycles apart.
- Also accepts a synchronous soft-reset request, so a domain can be re-reset without toggling the chip reset.

Parameters:
- NUM_STAGES, 2, synchroniser flop depth (legal >= 2).
- NUM_CH, 3, number of sequenced reset outputs (legal >= 1).
- MIN_ASSERT, 4, counted clk edges all outputs stay asserted after the synchronised reset/soft reset is released (legal >= 1).
- STAGGER, 2, clk edges between consecutive channel releases (legal >= 1).
- ORDER, 0, release order: 0 = channel 0 first (ascending), 1 = channel NUM_CH-1 first (descending).

Ports:
- clk  input  1  domain clock.
- RST  input  1  asynchronous active-low reset.
- SW_RST  input  1  synchronous active-high soft-reset request, level-sensitive, clk domain.
- SYNC_RST  output  NUM_CH  active-low sequenced resets; bit k feeds sub-block k.
- READY  output  1  high when every SYNC_RST bit is deasserted.

Behaviour:
- Interface: one clock, clk. RST is asynchronous, active-low.
- RST low, immediately and with no clock needed:
  - synchroniser chain cleared;
  - SYNC_RST = all 0; READY = 0;
  - FSM = HOLD; counters = 0.
- Synchroniser chain: NUM_STAGES flops shift in 1'b1; last stage = rst_ok. rst_ok rises on edge NUM_STAGES after RST is released (edge 1 = first edge sampling RST high).
- FSM states: HOLD, RELEASE, RUN.
  - HOLD:
    - all outputs 0.
    - Counter cleared on any edge where rst_ok = 0 or SW_RST = 1.
    - Counter increments on edges where rst_ok = 1 and SW_RST = 0.
    - On the MIN_ASSERT-th counted edge: release the first channel (ch0 if ORDER = 0, else ch NUM_CH-1) and go to RELEASE.
    - If NUM_CH = 1, go directly to RUN and assert READY on that same edge.
  - RELEASE:
    - Counter counts edges. Every STAGGER edges, release the next channel in ORDER.
    - The edge releasing the final channel also sets READY = 1 and moves to RUN.
  - RUN: all outputs 1, READY = 1; hold until SW_RST or RST.
- SW_RST sampled 1 in RELEASE or RUN:
  - next edge: SYNC_RST = all 0 (including already-released channels), READY = 0, counters cleared, FSM = HOLD.
  - Held high in HOLD: keeps the counter cleared.
- SW_RST timing: if SW_RST is first sampled low at edge S, the first channel releases at edge S+MIN_ASSERT-1.
- Power-on timing: first channel releases at edge NUM_STAGES+MIN_ASSERT.
- Channel j in release order (j = 0..NUM_CH-1) releases at first-release edge + j*STAGGER.
- Release is monotonic within a sequence: a released channel never reasserts except via SW_RST or RST.
- RST low mid-sequence (any state) overrides everything asynchronously. A new full sequence follows the next release.
- Simultaneous events: RST dominates SW_RST; SW_RST dominates a release due on the same edge (that channel stays 0).
- Counter width: $clog2(max(MIN_ASSERT, STAGGER)+1); no wrap is reachable.
- Outputs are driven directly by flops, so they are glitch-free.

Test Plan:
- Defaults (2/3/4/2/0), RST low 3 cycles then high before edge 1 -> SYNC_RST: 000 until edge 6; 001 at edge 6, 011 at edge 8, 111 at edge 10; READY = 1 at edge 10.
- ORDER = 1, same stimulus -> 100 at edge 6, 110 at 8, 111 at 10.
- In RUN, SW_RST high for 1 cycle (sampled edge T, low at T+1) -> 000 after edge T; 001 at T+4, 011 at T+6, 111 at T+8.
- SW_RST held high 10 cycles -> outputs 000 and READY = 0 throughout; release timing counts from the first low sample.
- SW_RST sampled on the same edge that would release ch1 (state 001) -> 000 next, ch1 not released; then the full MIN_ASSERT/STAGGER sequence.
- RST pulsed low mid-clock while state = 011 -> outputs 000 with no clock edge; after RST release, the full power-on timing repeats.
- NUM_CH = 1, MIN_ASSERT = 1, NUM_STAGES = 3 -> SYNC_RST and READY rise together at edge 4.
